// File: rtl/track_sequencer.sv
// Pan/tilt sequencer: turns per-field target detections into azimuth and
// elevation motor drive, sequencing search sweep, acquisition, closed-loop
// tracking and coast-on-loss. All state advances on the clock edge that ends
// the vsync rising-edge cycle; outputs hold between field edges.
module track_sequencer #(
    parameter int CENTER_COL   = 120,
    parameter int CENTER_LINE  = 131,
    parameter int DEAD_COL     = 4,
    parameter int DEAD_LINE    = 4,
    parameter int FAST_COL     = 28,
    parameter int FAST_LINE    = 30,
    parameter int ACQ_FIELDS   = 3,
    parameter int LOST_FIELDS  = 15,
    parameter int SWEEP_FIELDS = 60
) (
    input  logic       clk4mhz,
    input  logic       reset,
    input  logic       en,
    input  logic       vsync,
    input  logic       target_valid,
    input  logic [8:0] target_column,
    input  logic [8:0] target_line,
    output logic       az_en,
    output logic       az_dir,
    output logic       az_fast,
    output logic       el_en,
    output logic       el_dir,
    output logic       el_fast,
    output logic       locked,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        ACQUIRE = 3'd2,
        TRACK   = 3'd3,
        COAST   = 3'd4
    } trackState_t;

    localparam logic [8:0]  CENTER_COL_9   = 9'(CENTER_COL);
    localparam logic [8:0]  CENTER_LINE_9  = 9'(CENTER_LINE);
    localparam logic [9:0]  DEAD_COL_10    = 10'(DEAD_COL);
    localparam logic [9:0]  DEAD_LINE_10   = 10'(DEAD_LINE);
    localparam logic [9:0]  FAST_COL_10    = 10'(FAST_COL);
    localparam logic [9:0]  FAST_LINE_10   = 10'(FAST_LINE);
    localparam logic [7:0]  ACQ_FIELDS_8   = 8'(ACQ_FIELDS);
    localparam logic [7:0]  LOST_FIELDS_8  = 8'(LOST_FIELDS);
    localparam logic [7:0]  SWEEP_FIELDS_8 = 8'(SWEEP_FIELDS);

    // Counters stick at full scale instead of wrapping back to zero.
    function automatic logic [7:0] satInc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Signed pixel error of a 9-bit position against its boresight.
    function automatic logic signed [9:0] fieldError(input logic [8:0] pos,
                                                     input logic [8:0] center);
        return $signed({1'b0, pos}) - $signed({1'b0, center});
    endfunction

    // Magnitude of a signed error; the error range never reaches -512.
    function automatic logic [9:0] absErr(input logic signed [9:0] err);
        return err[9] ? $unsigned(-err) : $unsigned(err);
    endfunction

    trackState_t curState;
    trackState_t nextState;

    logic        vsyncQ;
    logic        fieldEdge;

    logic [7:0]  hitCnt;
    logic [7:0]  missCnt;
    logic [7:0]  sweepCnt;
    logic [7:0]  hitNext;
    logic [7:0]  missNext;
    logic [7:0]  sweepNext;
    logic [7:0]  hitInc;
    logic [7:0]  missInc;
    logic [7:0]  sweepInc;

    logic        azEnNext;
    logic        azDirNext;
    logic        azFastNext;
    logic        elEnNext;
    logic        elDirNext;
    logic        elFastNext;

    logic        driveTrack;
    logic        driveSearch;
    logic        driveOff;

    logic signed [9:0] errCol;
    logic signed [9:0] errLine;
    logic [9:0]  absCol;
    logic [9:0]  absLine;
    logic        trkAzEn;
    logic        trkAzDir;
    logic        trkAzFast;
    logic        trkElEn;
    logic        trkElDir;
    logic        trkElFast;

    assign fieldEdge = vsync & ~vsyncQ;
    assign hitInc    = satInc(hitCnt);
    assign missInc   = satInc(missCnt);
    assign sweepInc  = satInc(sweepCnt);

    // Closed-loop drive derived from the current target position.
    always_comb begin
        errCol    = fieldError(target_column, CENTER_COL_9);
        errLine   = fieldError(target_line, CENTER_LINE_9);
        absCol    = absErr(errCol);
        absLine   = absErr(errLine);
        trkAzEn   = absCol > DEAD_COL_10;
        trkAzFast = absCol > FAST_COL_10;
        trkAzDir  = target_column < CENTER_COL_9;
        trkElEn   = absLine > DEAD_LINE_10;
        trkElFast = absLine > FAST_LINE_10;
        trkElDir  = target_line < CENTER_LINE_9;
    end

    // Next-state, counter and motor decisions; everything holds unless a
    // field edge arrives or tracking is disabled.
    always_comb begin
        nextState   = curState;
        hitNext     = hitCnt;
        missNext    = missCnt;
        sweepNext   = sweepCnt;
        azDirNext   = az_dir;
        elDirNext   = el_dir;
        driveTrack  = 1'b0;
        driveSearch = 1'b0;
        driveOff    = 1'b0;

        if (!en) begin
            nextState = IDLE;
            hitNext   = 8'd0;
            missNext  = 8'd0;
            sweepNext = 8'd0;
            driveOff  = 1'b1;
        end else if (fieldEdge) begin
            unique case (curState)
                IDLE: begin
                    nextState   = SEARCH;
                    sweepNext   = 8'd0;
                    driveSearch = 1'b1;
                end
                SEARCH: begin
                    if (target_valid) begin
                        hitNext = 8'd1;
                        if (ACQ_FIELDS_8 <= 8'd1) begin
                            nextState  = TRACK;
                            missNext   = 8'd0;
                            driveTrack = 1'b1;
                        end else begin
                            nextState = ACQUIRE;
                            driveOff  = 1'b1;
                        end
                    end else begin
                        driveSearch = 1'b1;
                        if (sweepInc >= SWEEP_FIELDS_8) begin
                            // End of a sweep leg: reverse azimuth.
                            azDirNext = ~az_dir;
                            sweepNext = 8'd0;
                        end else begin
                            sweepNext = sweepInc;
                        end
                    end
                end
                ACQUIRE: begin
                    if (target_valid) begin
                        hitNext = hitInc;
                        if (hitInc >= ACQ_FIELDS_8) begin
                            nextState  = TRACK;
                            missNext   = 8'd0;
                            driveTrack = 1'b1;
                        end else begin
                            driveOff = 1'b1;
                        end
                    end else begin
                        nextState   = SEARCH;
                        hitNext     = 8'd0;
                        sweepNext   = 8'd0;
                        driveSearch = 1'b1;
                    end
                end
                TRACK: begin
                    if (target_valid) begin
                        missNext   = 8'd0;
                        driveTrack = 1'b1;
                    end else begin
                        nextState = COAST;
                        missNext  = 8'd1;
                        driveOff  = 1'b1;
                    end
                end
                COAST: begin
                    if (target_valid) begin
                        nextState  = TRACK;
                        missNext   = 8'd0;
                        driveTrack = 1'b1;
                    end else begin
                        missNext = missInc;
                        if (missInc >= LOST_FIELDS_8) begin
                            // Azimuth direction is kept so the sweep heads
                            // toward where the target was last seen.
                            nextState   = SEARCH;
                            sweepNext   = 8'd0;
                            driveSearch = 1'b1;
                        end else begin
                            driveOff = 1'b1;
                        end
                    end
                end
                default: begin
                    nextState = IDLE;
                    driveOff  = 1'b1;
                end
            endcase
        end
    end

    // Motor outputs selected by the decision above; directions only change
    // under closed-loop drive or a sweep reversal.
    always_comb begin
        azEnNext   = az_en;
        azFastNext = az_fast;
        elEnNext   = el_en;
        elFastNext = el_fast;
        if (driveTrack) begin
            azEnNext   = trkAzEn;
            azFastNext = trkAzFast;
            elEnNext   = trkElEn;
            elFastNext = trkElFast;
        end else if (driveSearch) begin
            azEnNext   = 1'b1;
            azFastNext = 1'b0;
            elEnNext   = 1'b0;
            elFastNext = 1'b0;
        end else if (driveOff) begin
            azEnNext   = 1'b0;
            azFastNext = 1'b0;
            elEnNext   = 1'b0;
            elFastNext = 1'b0;
        end
    end

    // State, counters, vsync history and registered motor outputs.
    always_ff @(posedge clk4mhz) begin
        if (reset) begin
            curState <= IDLE;
            vsyncQ   <= 1'b1;
            hitCnt   <= 8'd0;
            missCnt  <= 8'd0;
            sweepCnt <= 8'd0;
            az_en    <= 1'b0;
            az_dir   <= 1'b0;
            az_fast  <= 1'b0;
            el_en    <= 1'b0;
            el_dir   <= 1'b0;
            el_fast  <= 1'b0;
        end else begin
            curState <= nextState;
            vsyncQ   <= vsync;
            hitCnt   <= hitNext;
            missCnt  <= missNext;
            sweepCnt <= sweepNext;
            az_en    <= azEnNext;
            az_dir   <= (driveTrack) ? trkAzDir : azDirNext;
            az_fast  <= azFastNext;
            el_en    <= elEnNext;
            el_dir   <= (driveTrack) ? trkElDir : elDirNext;
            el_fast  <= elFastNext;
        end
    end

    assign locked = (curState == TRACK) || (curState == COAST);
    assign state  = curState;

endmodule
